rst_ctrl: RTL and testbench
===========================

RST_CTRL -- requirements
Module: rst_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the depth of the rstn deassertion synchronizer (legal range >=2).
REQ-002 SHALL have parameter HOLD_CYCLES, default 8, meaning the number of cycles rst_out_n is held low after sync release or a soft request (legal range 1..2^CNT_W).
REQ-003 SHALL have parameter CNT_W, default 4, meaning the hold counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-005 SHALL have port rstn, input, 1 bit: asynchronous active-low reset, asserted asynchronously.
REQ-006 SHALL have port sw_rst_req, input, 1 bit: soft reset request, sampled at posedge clk.
REQ-007 SHALL have port rst_out_n, output, 1 bit: registered active-low reset for downstream flops.
REQ-008 SHALL have port rst_busy, output, 1 bit: high while rst_out_n is low.
REQ-009 SHALL have port rst_done, output, 1 bit: one-cycle pulse on the edge at which rst_out_n rises.
REQ-010 SHALL have port soft_cnt, output, 8 bits: count of completed soft resets, saturating at 255.

Function
REQ-011 SHALL implement three states: ASSERT (rst_out_n=0), RUN (rst_out_n=1), SOFT (rst_out_n=0).
REQ-012 SHALL pass rstn through a SYNC_STAGES flop chain that is cleared asynchronously by rstn low and shifts in 1 each edge; rstn_s is the last stage.
REQ-013 SHALL, in ASSERT with rstn_s=0, hold cnt at 0.
REQ-014 SHALL, in ASSERT with rstn_s=1, increment cnt each edge; on the edge where cnt==HOLD_CYCLES-1, go to RUN, set rst_out_n=1, pulse rst_done, and clear cnt.
REQ-015 SHALL therefore raise rst_out_n exactly at edge SYNC_STAGES+HOLD_CYCLES, counting the first edge that samples rstn high as edge 1 (10 with defaults).
REQ-016 SHALL, in RUN with sw_rst_req=1, go to SOFT on that edge with rst_out_n=0, rst_busy=1, cnt=0.
REQ-017 SHALL, in SOFT, increment cnt each edge; on the edge where cnt==HOLD_CYCLES-1, go to RUN, set rst_out_n=1, pulse rst_done, and increment soft_cnt (saturating), so that rst_out_n is low for exactly HOLD_CYCLES cycles.
REQ-018 SHALL ignore sw_rst_req in ASSERT and SOFT; a request held high across the RUN entry edge SHALL be taken on the first RUN edge (back-to-back soft resets are allowed).
REQ-019 SHALL, with HOLD_CYCLES=1, hold rst_out_n low for exactly one cycle in SOFT.
REQ-020 SHALL assert rst_out_n low asynchronously (same delta as rstn fall, no clock needed) and never deassert it asynchronously.
REQ-021 SHALL keep rst_busy equal to ~rst_out_n at all times; rst_done SHALL never be high while rst_out_n is low.

Reset
REQ-022 SHALL, while rstn=0, asynchronously force: state=ASSERT, sync chain=0, cnt=0, rst_out_n=0, rst_busy=1, rst_done=0, soft_cnt=0.
REQ-023 SHALL, on rstn low mid-SOFT or mid-ASSERT, abort with no rst_done pulse and leave soft_cnt unchanged except for clearing.
REQ-024 SHALL treat an rstn glitch shorter than one clock period identically to a full reset: the complete SYNC_STAGES+HOLD_CYCLES sequence restarts.

Verification
REQ-025 Defaults; rstn low 3 cycles, then high -> rst_out_n=0 through edge 9, rises at edge 10; rst_done=1 for exactly that cycle; soft_cnt=0.
REQ-026 In RUN, one-cycle sw_rst_req -> rst_out_n low for exactly 8 cycles, rst_done pulse on the rising edge, soft_cnt=1.
REQ-027 sw_rst_req held high continuously -> repeated 8-low/1-high pattern; soft_cnt counts up and saturates at 255 after 255 completions.
REQ-028 rstn pulsed low between clock edges during SOFT cnt=5 -> rst_out_n falls immediately; no rst_done; soft_cnt=0; rst_out_n rises 10 edges after release.
REQ-029 sw_rst_req high during ASSERT -> ignored; sequence timing is unchanged (rise at edge 10).
REQ-030 SYNC_STAGES=3, HOLD_CYCLES=1 -> rst_out_n rises at edge 4; soft reset gives a single low cycle.

Source files
------------

// File: rtl/rst_ctrl.sv
// Reset controller: synchronised rstn release, hold counter,
// soft reset requests and a saturating soft reset count.
module rst_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sw_rst_req,
  output logic       rst_out_n,
  output logic       rst_busy,
  output logic       rst_done,
  output logic [7:0] soft_cnt
);

  typedef enum logic [1:0] {
    ASSERT,
    RUN,
    SOFT
  } state_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rstn_s;

  state_t     r_state;
  state_t     w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic       r_out_n;
  logic       w_out_n_nx;
  logic       r_done;
  logic       w_done_nx;
  logic [7:0] r_soft_cnt;
  logic [7:0] w_soft_cnt_nx;

  assign w_rstn_s  = r_sync[SYNC_STAGES-1];
  assign rst_out_n = r_out_n;
  assign rst_busy  = ~r_out_n;
  assign rst_done  = r_done;
  assign soft_cnt  = r_soft_cnt;

  // Release synchroniser: clears at once, fills with ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ASSERT;
      r_cnt      <= '0;
      r_out_n    <= 1'b0;
      r_done     <= 1'b0;
      r_soft_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_out_n    <= w_out_n_nx;
      r_done     <= w_done_nx;
      r_soft_cnt <= w_soft_cnt_nx;
    end
  end

  // Next state: hold counting and soft request handling.
  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_out_n_nx    = r_out_n;
    w_done_nx     = 1'b0;
    w_soft_cnt_nx = r_soft_cnt;
    unique case (r_state)
      ASSERT: begin
        w_out_n_nx = 1'b0;
        if (!w_rstn_s) begin
          w_cnt_nx = '0;
        end else if (r_cnt == LAST) begin
          w_state_nx = RUN;
          w_out_n_nx = 1'b1;
          w_done_nx  = 1'b1;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      RUN: begin
        w_out_n_nx = 1'b1;
        if (sw_rst_req) begin
          w_state_nx = SOFT;
          w_out_n_nx = 1'b0;
          w_cnt_nx   = '0;
        end
      end
      SOFT: begin
        w_out_n_nx = 1'b0;
        if (r_cnt == LAST) begin
          w_state_nx = RUN;
          w_out_n_nx = 1'b1;
          w_done_nx  = 1'b1;
          w_cnt_nx   = '0;
          if (r_soft_cnt != 8'hFF) begin
            w_soft_cnt_nx = r_soft_cnt + 8'd1;
          end
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = ASSERT;
        w_out_n_nx = 1'b0;
        w_cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rst_ctrl.sv
// Bench for rst_ctrl: two instances (2/8 and 3/1) against
// a timestamp model of reset release and soft resets.
module tb_rst_ctrl;

  logic clk;
  logic rstn0, req0, out0, busy0, done0;
  logic rstn1, req1, out1, busy1, done1;
  logic [7:0] sc0, sc1;

  int n_assert = 0;
  int n_fail   = 0;

  int m_S [2] = '{2, 3};
  int m_H [2] = '{8, 1};
  int m_rel  [2];
  int m_rise [2];
  int m_out  [2];
  int m_done [2];
  int m_sc   [2];
  int m_soft [2];

  rst_ctrl #(
    .SYNC_STAGES(2), .HOLD_CYCLES(8), .CNT_W(4)
  ) u0 (
    .clk(clk), .rstn(rstn0), .sw_rst_req(req0),
    .rst_out_n(out0), .rst_busy(busy0),
    .rst_done(done0), .soft_cnt(sc0)
  );

  rst_ctrl #(
    .SYNC_STAGES(3), .HOLD_CYCLES(1), .CNT_W(4)
  ) u1 (
    .clk(clk), .rstn(rstn1), .sw_rst_req(req1),
    .rst_out_n(out1), .rst_busy(busy1),
    .rst_done(done1), .soft_cnt(sc1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time %0t limit reached", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_rel[k]  = 0;
    m_rise[k] = m_S[k] + m_H[k];
    m_out[k]  = 0;
    m_done[k] = 0;
    m_sc[k]   = 0;
    m_soft[k] = 0;
  endtask

  // Rise time is a timestamp in edges since release.
  task automatic model_edge(input int k,
                            input logic rn,
                            input logic rq);
    if (!rn) begin
      model_reset(k);
    end else begin
      m_rel[k]++;
      m_done[k] = 0;
      if (m_out[k] == 0) begin
        if (m_rel[k] == m_rise[k]) begin
          m_out[k]  = 1;
          m_done[k] = 1;
          if (m_soft[k] != 0 && m_sc[k] < 255)
            m_sc[k]++;
        end
      end else if (rq) begin
        m_out[k]  = 0;
        m_soft[k] = 1;
        m_rise[k] = m_rel[k] + m_H[k];
      end
    end
  endtask

  task automatic check_unit(input string t, input int k,
                            input logic o, input logic b,
                            input logic d,
                            input logic [7:0] s);
    chk({t, ".rst_out_n"}, int'(o), m_out[k]);
    chk({t, ".rst_busy"}, int'(b), 1 - m_out[k]);
    chk({t, ".rst_done"}, int'(d), m_done[k]);
    chk({t, ".soft_cnt"}, int'(s), m_sc[k]);
    if (d && !o)
      chk({t, ".done_while_low"}, 1, 0);
  endtask

  task automatic check_all();
    check_unit("u0", 0, out0, busy0, done0, sc0);
    check_unit("u1", 1, out1, busy1, done1, sc1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0, rstn0, req0);
    model_edge(1, rstn1, req1);
    #1;
    check_all();
  endtask

  // Short rstn pulse between edges.
  task automatic glitch(input int k);
    if (k == 0) rstn0 = 1'b0;
    else        rstn1 = 1'b0;
    model_reset(k);
    #1;
    check_all();
    #1;
    if (k == 0) rstn0 = 1'b1;
    else        rstn1 = 1'b1;
  endtask

  initial begin
    int r0, r1, lows, seen;
    rstn0 = 1'b1; rstn1 = 1'b1;
    req0  = 1'b0; req1  = 1'b0;
    #2;
    rstn0 = 1'b0; rstn1 = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    chk("rst.out0", int'(out0), 0);
    chk("rst.busy0", int'(busy0), 1);
    chk("rst.done0", int'(done0), 0);
    chk("rst.sc0", int'(sc0), 0);
    chk("rst.out1", int'(out1), 0);
    check_all();
    for (int i = 0; i < 3; i++) tick();

    // Release with requests ignored during ASSERT.
    rstn0 = 1'b1; rstn1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    r0 = 0; r1 = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 6) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      if (out0 && r0 == 0) begin
        r0 = i;
        chk("boot.done0", int'(done0), 1);
      end
      if (out1 && r1 == 0) begin
        r1 = i;
        chk("boot.done1", int'(done1), 1);
      end
    end
    chk("boot.rise_edge0", r0, 10);
    chk("boot.rise_edge1", r1, 4);
    chk("boot.sc0", int'(sc0), 0);

    // Single soft request on unit 0.
    tick();
    req0 = 1'b1;
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) req0 = 1'b0;
      if (!out0) lows++;
    end
    chk("soft.low_cycles0", lows, 8);
    chk("soft.sc0", int'(sc0), 1);

    // Random requests and reset glitches.
    for (int i = 0; i < 400; i++) begin
      req0 = ($urandom_range(0, 3) == 0);
      req1 = ($urandom_range(0, 2) == 0);
      tick();
      if ($urandom_range(0, 49) == 0)
        glitch(int'($urandom_range(0, 1)));
      if ($urandom_range(0, 99) == 0) begin
        rstn1 = 1'b0;
        model_reset(1);
        #1;
        check_all();
        for (int j = 0; j < 3; j++) tick();
        rstn1 = 1'b1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;

    // Abort a soft reset at cnt=5.
    seen = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      tick();
      if (out0) seen = 1;
    end
    chk("abort.wait_run", seen, 1);
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("abort.pre_out0", int'(out0), 0);
    glitch(0);
    chk("abort.out0", int'(out0), 0);
    chk("abort.sc0", int'(sc0), 0);
    chk("abort.done0", int'(done0), 0);
    r0 = 0;
    for (int i = 1; i <= 30 && r0 == 0; i++) begin
      tick();
      if (out0) r0 = i;
    end
    chk("abort.rise_edge0", r0, 10);

    // Held request: back-to-back and saturation.
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 255 * 9 + 30; i++) tick();
    chk("sat.sc0", int'(sc0), 255);
    chk("sat.sc1", int'(sc1), 255);
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("sat.hold_sc0", int'(sc0), 255);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
